// File: rtl/adc_seq_pkg.sv
// Shared constants, word layout and channel-mask helpers for the ADC scan sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package adc_seq_pkg;

  localparam int WORD_W     = 16;
  localparam int SAMPLE_W   = 12;
  localparam int NUM_CH     = 8;
  localparam int CH_W       = 3;
  localparam int TAG_MSB    = 15;
  localparam int TAG_LSB    = 13;
  localparam int SAMPLE_MSB = 11;

  // One SPI word as it arrives MSB first: tag, reserved bit, sample.
  typedef struct packed {
    logic [CH_W-1:0]     tag;
    logic                rsvd;
    logic [SAMPLE_W-1:0] sample;
  } word_t;

  // Next set bit of mask strictly above ch, wrapping; ch itself if it is the only one; 0 if mask empty.
  function automatic logic [CH_W-1:0] next_enabled(input logic [NUM_CH-1:0] mask,
                                                    input logic [CH_W-1:0]   ch);
    logic [CH_W-1:0] idx;
    logic            found;
    next_enabled = '0;
    found        = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = ch + CH_W'(i);
      if (!found && mask[idx]) begin
        next_enabled = idx;
        found        = 1'b1;
      end
    end
  endfunction

  // Highest set bit of mask; marks the channel that closes a scan.
  function automatic logic [CH_W-1:0] highest_enabled(input logic [NUM_CH-1:0] mask);
    highest_enabled = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[i]) highest_enabled = CH_W'(i);
    end
  endfunction

endpackage

// File: rtl/adc_word_shifter.sv
// SPI slave deserialiser: shifts MOSI MSB first and presents each complete 16-bit word.
// Latency: word/word_strobe valid combinationally during the 16th bit, consumed on that same edge.
// Backpressure: none; raising spi_nss discards any partial word and restarts the bit count.
module adc_word_shifter
  import adc_seq_pkg::*;
(
  input  logic              spi_clock_in,
  input  logic              reset,
  input  logic              spi_nss,
  input  logic              spi_data_in,
  output logic [WORD_W-1:0] word,
  output logic              word_strobe
);

  logic              clr;
  logic [WORD_W-2:0] sh_q, sh_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;

  // Frame deselect behaves like a reset for the shifter only.
  assign clr = reset | spi_nss;

  // Shift in one bit per edge; the 4-bit counter wraps 15 -> 0 at each word boundary.
  always_comb begin
    sh_d      = {sh_q[WORD_W-3:0], spi_data_in};
    bit_cnt_d = bit_cnt_q + 4'd1;
  end

  // Shifter state, asynchronously cleared by reset or deselect.
  always_ff @(posedge spi_clock_in or posedge clr) begin
    if (clr) begin
      sh_q      <= '0;
      bit_cnt_q <= '0;
    end else begin
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // The last bit is taken straight from the pin so the word lands with no extra cycle.
  assign word        = {sh_q, spi_data_in};
  assign word_strobe = (bit_cnt_q == 4'd15) && !spi_nss;

endmodule

// File: rtl/adc_scan_sequencer.sv
// ADC scan sequencer: checks round-robin channel order, banks latest samples, signals clean scans by toggle.
// Latency: all state updates on the 16th rising edge of each word, no extra cycles.
// Backpressure: none; words arrive at SPI rate and are always accepted or flagged.
module adc_scan_sequencer
  import adc_seq_pkg::*;
(
  input  logic                         spi_clock_in,
  input  logic                         reset,
  input  logic                         spi_nss,
  input  logic                         spi_data_in,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic                         err_clr,
  output logic [NUM_CH*SAMPLE_W-1:0]   samples,
  output logic [NUM_CH-1:0]            sample_valid,
  output logic                         seq_error,
  output logic                         scan_done_tgl,
  output logic [7:0]                   scan_count,
  output logic [CH_W-1:0]              expected_ch
);

  logic [WORD_W-1:0] word;
  logic              word_strobe;
  word_t             wf;
  logic              rsvd_unused;
  logic [CH_W-1:0]   exp_cur;
  logic              in_order;

  logic [NUM_CH-1:0][SAMPLE_W-1:0] samples_q, samples_d;
  logic [NUM_CH-1:0]               sample_valid_q, sample_valid_d;
  logic                            seq_error_q, seq_error_d;
  logic                            scan_done_tgl_q, scan_done_tgl_d;
  logic [7:0]                      scan_count_q, scan_count_d;
  logic [CH_W-1:0]                 expected_ch_q, expected_ch_d;
  logic                            exp_loaded_q, exp_loaded_d;
  logic                            scan_clean_q, scan_clean_d;

  adc_word_shifter u_shifter (
    .spi_clock_in (spi_clock_in),
    .reset        (reset),
    .spi_nss      (spi_nss),
    .spi_data_in  (spi_data_in),
    .word         (word),
    .word_strobe  (word_strobe)
  );

  assign wf          = word_t'(word);
  assign rsvd_unused = wf.rsvd;

  // Until the first enabled word is accepted, the expected channel tracks the lowest enabled bit of the mask.
  assign exp_cur  = exp_loaded_q ? expected_ch_q : next_enabled(ch_enable, CH_W'(NUM_CH - 1));
  assign in_order = (wf.tag == exp_cur);

  // Sequencer: classify each completed word, store it, track order and scan completion.
  always_comb begin
    samples_d       = samples_q;
    sample_valid_d  = sample_valid_q;
    seq_error_d     = err_clr ? 1'b0 : seq_error_q;
    scan_done_tgl_d = scan_done_tgl_q;
    scan_count_d    = scan_count_q;
    expected_ch_d   = expected_ch_q;
    exp_loaded_d    = exp_loaded_q;
    scan_clean_d    = scan_clean_q;
    if (word_strobe) begin
      if (!ch_enable[wf.tag]) begin
        // Disabled tag: drop the sample, leave ordering untouched.
        seq_error_d = 1'b1;
      end else begin
        samples_d[wf.tag]      = wf.sample;
        sample_valid_d[wf.tag] = 1'b1;
        expected_ch_d          = next_enabled(ch_enable, wf.tag);
        exp_loaded_d           = 1'b1;
        if (!in_order) begin
          // Out of order: keep the data, resync on this tag, spoil the current scan.
          seq_error_d  = 1'b1;
          scan_clean_d = 1'b0;
        end
        if (wf.tag == highest_enabled(ch_enable)) begin
          if (scan_clean_q && in_order) begin
            scan_done_tgl_d = ~scan_done_tgl_q;
            scan_count_d    = scan_count_q + 8'd1;
          end
          scan_clean_d = 1'b1;
        end
      end
    end
  end

  // Sequencer state registers.
  always_ff @(posedge spi_clock_in or posedge reset) begin
    if (reset) begin
      samples_q       <= '0;
      sample_valid_q  <= '0;
      seq_error_q     <= 1'b0;
      scan_done_tgl_q <= 1'b0;
      scan_count_q    <= '0;
      expected_ch_q   <= '0;
      exp_loaded_q    <= 1'b0;
      scan_clean_q    <= 1'b1;
    end else begin
      samples_q       <= samples_d;
      sample_valid_q  <= sample_valid_d;
      seq_error_q     <= seq_error_d;
      scan_done_tgl_q <= scan_done_tgl_d;
      scan_count_q    <= scan_count_d;
      expected_ch_q   <= expected_ch_d;
      exp_loaded_q    <= exp_loaded_d;
      scan_clean_q    <= scan_clean_d;
    end
  end

  assign samples       = samples_q;
  assign sample_valid  = sample_valid_q;
  assign seq_error     = seq_error_q;
  assign scan_done_tgl = scan_done_tgl_q;
  assign scan_count    = scan_count_q;
  assign expected_ch   = exp_cur;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Self-checking bench for adc_scan_sequencer against a behavioural scan model.
// Latency: checks taken on the falling edge after the 16th bit of each word.
// Backpressure: n/a.
module tb_adc_scan_sequencer;

  logic        spi_clock_in;
  logic        reset;
  logic        spi_nss;
  logic        spi_data_in;
  logic [7:0]  ch_enable;
  logic        err_clr;
  logic [95:0] samples;
  logic [7:0]  sample_valid;
  logic        seq_error;
  logic        scan_done_tgl;
  logic [7:0]  scan_count;
  logic [2:0]  expected_ch;

  int checks = 0;
  int errors = 0;

  adc_scan_sequencer dut (
    .spi_clock_in  (spi_clock_in),
    .reset         (reset),
    .spi_nss       (spi_nss),
    .spi_data_in   (spi_data_in),
    .ch_enable     (ch_enable),
    .err_clr       (err_clr),
    .samples       (samples),
    .sample_valid  (sample_valid),
    .seq_error     (seq_error),
    .scan_done_tgl (scan_done_tgl),
    .scan_count    (scan_count),
    .expected_ch   (expected_ch)
  );

  initial begin
    spi_clock_in = 1'b0;
    forever #5 spi_clock_in = ~spi_clock_in;
  end

  // Behavioural model of the scan rules.
  logic [11:0] m_samp [8];
  logic [7:0]  m_mask;
  logic [7:0]  m_valid;
  logic        m_err;
  logic        m_tgl;
  logic        m_clean;
  logic [7:0]  m_count;
  int          m_exp;

  function automatic int m_next(input int c);
    for (int k = 1; k <= 8; k++) if (m_mask[(c + k) % 8]) return (c + k) % 8;
    return 0;
  endfunction

  function automatic int m_highest();
    int h = 0;
    for (int k = 0; k < 8; k++) if (m_mask[k]) h = k;
    return h;
  endfunction

  function automatic void model_reset(input logic [7:0] m);
    m_mask = m;
    for (int k = 0; k < 8; k++) m_samp[k] = '0;
    m_valid = '0; m_err = 0; m_tgl = 0; m_clean = 1; m_count = '0;
    m_exp = m_next(7);
  endfunction

  function automatic void model_word(input logic [15:0] w);
    int t = int'(w[15:13]);
    if (!m_mask[t]) begin
      m_err = 1;
    end else begin
      m_samp[t] = w[11:0];
      m_valid[t] = 1;
      if (t != m_exp) begin
        m_err = 1;
        m_clean = 0;
      end
      if (t == m_highest()) begin
        if (m_clean) begin
          m_tgl = ~m_tgl;
          m_count = m_count + 8'd1;
        end
        m_clean = 1;
      end
      m_exp = m_next(t);
    end
  endfunction

  function automatic logic [116:0] model_vec();
    logic [95:0] s;
    for (int k = 0; k < 8; k++) s[12*k +: 12] = m_samp[k];
    return {s, m_valid, m_err, m_tgl, m_count, 3'(m_exp)};
  endfunction

  function automatic logic [116:0] dut_vec();
    return {samples, sample_valid, seq_error, scan_done_tgl, scan_count, expected_ch};
  endfunction

  // Stimulus primitives (called at a falling edge, return at a falling edge).
  task automatic do_reset(input logic [7:0] m);
    @(negedge spi_clock_in);
    reset = 1; spi_nss = 1; spi_data_in = 0; err_clr = 0; ch_enable = m;
    model_reset(m);
    @(negedge spi_clock_in);
    reset = 0;
    @(negedge spi_clock_in);
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 15; i > 15 - n; i--) begin
      spi_data_in = w[i];
      @(negedge spi_clock_in);
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    send_bits(w, 16);
    model_word(w);
  endtask

  task automatic frame_start();
    spi_nss = 0;
  endtask

  task automatic frame_end();
    spi_nss = 1;
    @(negedge spi_clock_in);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1;
    @(negedge spi_clock_in);
    err_clr = 0;
    m_err = 0;
  endtask

  task automatic test_reset();
    @(negedge spi_clock_in);
    reset = 1; spi_nss = 1; ch_enable = 8'h0C; err_clr = 0;
    #1;
    checks++;
    if (dut_vec() !== {96'h0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd2}) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", dut_vec(), {96'h0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd2});
    end
    @(negedge spi_clock_in);
    reset = 0;
  endtask

  task automatic test_basic_scan();
    do_reset(8'h0F);
    frame_start();
    send_word(16'h0123); send_word(16'h2456); send_word(16'h4789); send_word(16'h6ABC);
    checks++;
    if (samples[47:0] !== 48'hABC789456123 || sample_valid !== 8'h0F || scan_done_tgl !== 1'b1 ||
        scan_count !== 8'd1 || seq_error !== 1'b0) begin
      errors++;
      $display("FAIL basic_scan: got samp=%h valid=%h tgl=%b cnt=%0d err=%b want samp=abc789456123 valid=0f tgl=1 cnt=1 err=0",
               samples[47:0], sample_valid, scan_done_tgl, scan_count, seq_error);
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL basic_scan_model: got %h want %h", dut_vec(), model_vec());
    end
    frame_end();
  endtask

  task automatic test_two_ch();
    int tags [4] = '{0, 2, 0, 2};
    int exps [4] = '{2, 0, 2, 0};
    do_reset(8'h05);
    frame_start();
    for (int i = 0; i < 4; i++) begin
      send_word({3'(tags[i]), 13'($urandom)});
      checks++;
      if (expected_ch !== 3'(exps[i])) begin
        errors++;
        $display("FAIL two_ch_expected[%0d]: got %0d want %0d", i, expected_ch, exps[i]);
      end
    end
    checks++;
    if (scan_count !== 8'd2 || scan_done_tgl !== 1'b0 || seq_error !== 1'b0) begin
      errors++;
      $display("FAIL two_ch_scans: got cnt=%0d tgl=%b err=%b want cnt=2 tgl=0 err=0", scan_count, scan_done_tgl, seq_error);
    end
    frame_end();
  endtask

  task automatic test_seq_error_clear();
    do_reset(8'h0F);
    frame_start();
    send_word(16'h0111); send_word(16'h4222); send_word(16'h6333);
    checks++;
    if (seq_error !== 1'b1 || scan_done_tgl !== 1'b0 || expected_ch !== 3'd0) begin
      errors++;
      $display("FAIL seq_error_set: got err=%b tgl=%b exp=%0d want err=1 tgl=0 exp=0", seq_error, scan_done_tgl, expected_ch);
    end
    frame_end();
    pulse_err_clr();
    frame_start();
    for (int i = 0; i < 4; i++) send_word({3'(i), 13'($urandom)});
    checks++;
    if (seq_error !== 1'b0 || scan_done_tgl !== 1'b1 || scan_count !== 8'd1) begin
      errors++;
      $display("FAIL seq_error_clear: got err=%b tgl=%b cnt=%0d want err=0 tgl=1 cnt=1", seq_error, scan_done_tgl, scan_count);
    end
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL seq_error_model: got %h want %h", dut_vec(), model_vec());
    end
    frame_end();
  endtask

  task automatic test_partial_word();
    do_reset(8'h02);
    frame_start();
    send_bits(16'($urandom), 9);
    frame_end();
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL partial_untouched: got %h want %h", dut_vec(), model_vec());
    end
    frame_start();
    send_word(16'h35A5);
    checks++;
    if (sample_valid !== 8'h02 || samples !== {72'h0, 12'h5A5, 12'h0}) begin
      errors++;
      $display("FAIL partial_then_word: got valid=%h samp=%h want valid=02 samp=5a5000", sample_valid, samples);
    end
    frame_end();
  endtask

  task automatic test_bad_tag();
    do_reset(8'h0F);
    frame_start();
    send_word(16'h0777);
    send_word(16'hA999);
    checks++;
    if (seq_error !== 1'b1 || samples !== {84'h0, 12'h777} || expected_ch !== 3'd1) begin
      errors++;
      $display("FAIL bad_tag: got err=%b samp=%h exp=%0d want err=1 samp=777 exp=1", seq_error, samples, expected_ch);
    end
    frame_end();
  endtask

  task automatic test_reset_midword();
    do_reset(8'h0F);
    frame_start();
    send_word(16'h0AAA); send_word(16'h2BBB);
    send_bits(16'h4CCC, 8);
    #2 reset = 1;
    #1;
    checks++;
    if (dut_vec() !== {96'h0, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0}) begin
      errors++;
      $display("FAIL reset_midword_state: got %h want all-zero", dut_vec());
    end
    spi_nss = 1;
    @(negedge spi_clock_in);
    reset = 0;
    model_reset(8'h0F);
    @(negedge spi_clock_in);
    frame_start();
    for (int i = 0; i < 4; i++) send_word({3'(i), 13'($urandom)});
    checks++;
    if (scan_count !== 8'd1 || scan_done_tgl !== 1'b1 || seq_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_midword_rescan: got cnt=%0d tgl=%b err=%b want cnt=1 tgl=1 err=0", scan_count, scan_done_tgl, seq_error);
    end
    frame_end();
  endtask

  task automatic test_random();
    logic [7:0] masks [6];
    masks[0] = 8'h00; masks[1] = 8'h80;
    for (int i = 2; i < 6; i++) masks[i] = 8'($urandom);
    for (int mi = 0; mi < 6; mi++) begin
      do_reset(masks[mi]);
      frame_start();
      for (int n = 0; n < 40; n++) begin
        int r = int'($urandom_range(0, 99));
        logic [2:0] tag;
        if (r < 5) begin
          frame_end();
          pulse_err_clr();
          frame_start();
        end else if (r < 9) begin
          send_bits(16'($urandom), int'($urandom_range(1, 15)));
          frame_end();
          frame_start();
        end
        tag = (r < 75) ? 3'(m_exp) : 3'($urandom_range(0, 7));
        send_word({tag, 13'($urandom)});
        checks++;
        if (dut_vec() !== model_vec()) begin
          errors++;
          $display("FAIL random[m%0d w%0d]: got %h want %h", mi, n, dut_vec(), model_vec());
        end
      end
      frame_end();
    end
  endtask

  initial begin
    reset = 1; spi_nss = 1; spi_data_in = 0; ch_enable = 8'h00; err_clr = 0;
    test_reset();
    test_basic_scan();
    test_two_ch();
    test_seq_error_clear();
    test_partial_word();
    test_bad_tag();
    test_reset_midword();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
